darksoc_dbgio: RTL and testbench
================================

DARKSOC_DBGIO -- requirements
Module: darksoc_dbgio

Interface
REQ-001 SHALL have parameter MBX_DEPTH, default 4, mailbox FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port XCLK  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port XRES  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port REQ  in  1  bus request; held by the core until ACK.
REQ-005 SHALL have port WR  in  1  1=write, 0=read; qualified by REQ.
REQ-006 SHALL have port ADDR  in  5  byte address; bits[1:0] ignored.
REQ-007 SHALL have port BE  in  4  write byte enables.
REQ-008 SHALL have port WDATA  in  32  write data.
REQ-009 SHALL have port RDATA  out  32  read data; valid only while ACK=1, 0 otherwise.
REQ-010 SHALL have port ACK  out  1  one-cycle transfer acknowledge.
REQ-011 SHALL have port DEBUG  out  4x32  registered debug words to the bench.
REQ-012 SHALL have port LED  out  4  registered LED bits.
REQ-013 SHALL have port MBX_VALID  out  1  mailbox head byte available.
REQ-014 SHALL have port MBX_DATA  out  8  mailbox head byte; meaningful only while MBX_VALID=1.
REQ-015 SHALL have port MBX_READY  in  1  bench consumes head byte.

Function
REQ-016 SHALL accept a request at a rising edge where REQ=1 and ACK=0; requests seen while ACK=1 are ignored.
REQ-017 SHALL assert ACK for exactly one cycle, in the cycle after acceptance (latency 1); RDATA is registered at the acceptance edge.
REQ-018 SHALL apply write effects at the acceptance edge, so they are visible on the outputs in the ACK cycle.
REQ-019 SHALL decode word offsets 0x00/0x04/0x08/0x0C as DEBUG[0..3]: RW, per-byte writes under BE.
REQ-020 SHALL decode offset 0x10 as LED: bits[3:0] RW under BE[0]; upper bits read 0.
REQ-021 SHALL decode offset 0x14 as CYCLE: RO, value at the acceptance edge; writes ignored.
REQ-022 SHALL decode offset 0x18 as MBX: a write with BE[0]=1 pushes WDATA[7:0]; a write with BE[0]=0 is ignored.
REQ-023 SHALL return MBX status on a read of 0x18: bit0 full, bit1 empty, bits[7:4] count, bit8 OVF; all other bits 0.
REQ-024 SHALL treat offset 0x1C as reserved: reads return 0, writes ignored, ACK still given.
REQ-025 SHALL implement CYCLE as a 32-bit counter that increments every cycle XRES=1 and wraps 0xFFFFFFFF->0.
REQ-026 SHALL implement the mailbox as a FIFO with MBX_DEPTH entries; pointers wrap modulo MBX_DEPTH, and the count ranges 0..MBX_DEPTH.
REQ-027 SHALL register MBX_VALID=(count!=0), with MBX_DATA the head entry; a push into an empty FIFO raises MBX_VALID in the ACK cycle.
REQ-028 SHALL pop at an edge where MBX_VALID=1 and MBX_READY=1; MBX_READY with MBX_VALID=0 has no effect.
REQ-029 SHALL perform both a push and a pop on the same edge when they coincide, whether full or not; count is unchanged.
REQ-030 SHALL, on a push when full with no simultaneous pop, drop the byte, leave the contents unchanged and set OVF sticky.
REQ-031 SHALL clear OVF at the acceptance edge of a read of 0x18, returning the pre-clear value; an overflow on that same edge wins, and OVF stays 1.
REQ-032 SHALL keep DEBUG and LED stable except on addressed writes.

Reset
REQ-033 SHALL, while XRES=0 at an edge, clear DEBUG, LED, CYCLE, FIFO pointers and count, OVF, ACK, RDATA and MBX_VALID, and drive MBX_DATA to 0.
REQ-034 SHALL discard any request accepted at or pending across reset: no ACK is issued, and no write takes effect.
REQ-035 SHALL ignore REQ while XRES=0, with the first acceptance possible at the first edge after XRES returns to 1.

Verification
REQ-036 Bench SHALL check reset release: hold XRES=0 for 2 edges then release -> all outputs 0, CYCLE reads 1..3 on an immediate read, and ACK occurs exactly one cycle after REQ.
REQ-037 Bench SHALL check byte-enabled writes: write 0xDEADBEEF to 0x04 with BE=0xF, then 0x00000011 with BE=0x1 -> DEBUG[1]=0xDEADBE11, and a read of 0x04 returns the same.
REQ-038 Bench SHALL check LED: write 0xFFFFFFFF to 0x10 -> LED=0xF, and a readback returns 0x0000000F.
REQ-039 Bench SHALL check mailbox overflow: push 'A','B','C','D','E' with MBX_READY=0 -> status read 0x141 (full, count 4, OVF); the next status read returns 0x041; popping yields 'A'..'D', then MBX_VALID=0 and status 0x002.
REQ-040 Bench SHALL check simultaneous push and pop: with the FIFO full and MBX_READY=1, push 'Z' -> count stays 4, 'Z' is last out, and OVF stays 0.
REQ-041 Bench SHALL check reset mid-transaction: assert REQ write 0x55 to 0x08, then pull XRES=0 on the acceptance edge -> no ACK, DEBUG[2]=0 after release.

Source files
------------

// File: rtl/darksoc_dbgio.sv
// Debug I/O block for the darksoc core: debug words, LEDs, free-running cycle
// counter and a byte mailbox FIFO drained by the bench, on a 1-cycle-ack bus.
module darksoc_dbgio #(
  parameter int unsigned MBX_DEPTH = 4
) (
  input  logic             XCLK,
  input  logic             XRES,
  input  logic             REQ,
  input  logic             WR,
  input  logic [4:0]       ADDR,
  input  logic [3:0]       BE,
  input  logic [31:0]      WDATA,
  output logic [31:0]      RDATA,
  output logic             ACK,
  output logic [3:0][31:0] DEBUG,
  output logic [3:0]       LED,
  output logic             MBX_VALID,
  output logic [7:0]       MBX_DATA,
  input  logic             MBX_READY
);

  localparam int unsigned PW = (MBX_DEPTH > 1) ? $clog2(MBX_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] IDX_LED   = 3'd4;
  localparam logic [2:0] IDX_CYCLE = 3'd5;
  localparam logic [2:0] IDX_MBX   = 3'd6;

  logic [31:0]   cycle;
  logic          ovf;
  logic [7:0]    mem [MBX_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          accept;
  logic          wr_acc;
  logic          rd_acc;
  logic [2:0]    idx;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          ovf_evt;
  logic [31:0]   status;
  logic [31:0]   rd_mux;
  logic [CW-1:0] next_count;
  logic [PW-1:0] next_rd;
  logic [7:0]    next_head;

  // Byte-lane address bits carry no meaning on this word-oriented bus.
  wire unused_addr = &{1'b0, ADDR[1:0]};

  // Request decode and mailbox control.
  always_comb begin
    idx        = ADDR[4:2];
    accept     = XRES & REQ & ~ACK;
    wr_acc     = accept & WR;
    rd_acc     = accept & ~WR;
    full       = (count == CW'(MBX_DEPTH));
    empty      = (count == '0);
    pop        = MBX_VALID & MBX_READY;
    push_req   = wr_acc & (idx == IDX_MBX) & BE[0];
    push       = push_req & (~full | pop);
    ovf_evt    = push_req & full & ~pop;
    status     = {23'd0, ovf, 4'(count), 2'b00, empty, full};
    next_count = count;
    if (push && !pop) next_count = count + CW'(1);
    if (pop && !push) next_count = count - CW'(1);
    next_rd    = pop ? rd_ptr + PW'(1) : rd_ptr;
    // A byte pushed into the slot that becomes head bypasses the array.
    next_head  = (push && (wr_ptr == next_rd)) ? WDATA[7:0] : mem[next_rd];
  end

  // Read data mux; CYCLE reports the count including the acceptance edge.
  always_comb begin
    rd_mux = 32'd0;
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = DEBUG[idx[1:0]];
      IDX_LED:                rd_mux = {28'd0, LED};
      IDX_CYCLE:              rd_mux = cycle + 32'd1;
      IDX_MBX:                rd_mux = status;
      default:                rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge XCLK) begin
    if (!XRES) begin
      ACK       <= 1'b0;
      RDATA     <= 32'd0;
      DEBUG     <= '0;
      LED       <= 4'd0;
      cycle     <= 32'd0;
      ovf       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      MBX_VALID <= 1'b0;
      MBX_DATA  <= 8'd0;
    end else begin
      ACK   <= accept;
      RDATA <= rd_acc ? rd_mux : 32'd0;
      cycle <= cycle + 32'd1;
      if (wr_acc && (idx < IDX_LED)) begin
        for (int b = 0; b < 4; b++) begin
          if (BE[b]) DEBUG[idx[1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
        end
      end
      if (wr_acc && (idx == IDX_LED) && BE[0]) LED <= WDATA[3:0];
      // Overflow on the clearing edge keeps the flag set.
      if (ovf_evt) ovf <= 1'b1;
      else if (rd_acc && (idx == IDX_MBX)) ovf <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr    <= next_rd;
      count     <= next_count;
      MBX_VALID <= (next_count != '0);
      MBX_DATA  <= (next_count != '0) ? next_head : 8'd0;
    end
  end

  // Mailbox storage; contents need no reset since count gates visibility.
  always_ff @(posedge XCLK) begin
    if (push) mem[wr_ptr] <= WDATA[7:0];
  end

endmodule

// File: tb/tb_darksoc_dbgio.sv
// Self-checking bench for darksoc_dbgio: directed scenarios plus a randomized
// run compared against a queue-based behavioural model.
module tb_darksoc_dbgio;

  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             xres;
  logic             req;
  logic             wr;
  logic [4:0]       addr;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             ack;
  logic [3:0][31:0] debug;
  logic [3:0]       led;
  logic             mbx_valid;
  logic [7:0]       mbx_data;
  logic             mbx_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  darksoc_dbgio #(.MBX_DEPTH(DEPTH)) dut (
    .XCLK(clk), .XRES(xres), .REQ(req), .WR(wr), .ADDR(addr), .BE(be),
    .WDATA(wdata), .RDATA(rdata), .ACK(ack), .DEBUG(debug), .LED(led),
    .MBX_VALID(mbx_valid), .MBX_DATA(mbx_data), .MBX_READY(mbx_ready)
  );

  // Bus driver: holds REQ until ACK is seen (bounded), returns at the ACK cycle.
  task automatic bus(input logic w, input logic [4:0] a, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] rd);
    bit got = 0;
    rd = '0;
    req = 1'b1; wr = w; addr = a; be = b; wdata = d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin got = 1; rd = rdata; break; end
    end
    req = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bus_timeout addr=%h: no ACK seen, required within 8 cycles", a);
    end
  endtask

  task automatic test_reset();
    xres = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0; mbx_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ack); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++; if (debug !== '0) begin errors++; $display("FAIL rst_debug got=%h exp=0", debug); end
    checks++; if (led !== 4'd0) begin errors++; $display("FAIL rst_led got=%h exp=0", led); end
    checks++; if (mbx_valid !== 1'b0) begin errors++; $display("FAIL rst_mbx_valid got=%b exp=0", mbx_valid); end
    checks++; if (mbx_data !== 8'd0) begin errors++; $display("FAIL rst_mbx_data got=%h exp=0", mbx_data); end
    xres = 1'b1; req = 1'b1; wr = 1'b0; addr = 5'h14;
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rst_first_ack got=%b exp=1", ack); end
    checks++;
    if (rdata < 32'd1 || rdata > 32'd3) begin
      errors++; $display("FAIL rst_cycle got=%0d exp=1..3", rdata);
    end
    req = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack_width got=%b exp=0", ack); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL rst_rdata_idle got=%h exp=0", rdata); end
  endtask

  task automatic test_byte_en();
    logic [31:0] r;
    bus(1'b1, 5'h04, 4'hF, 32'hDEADBEEF, r);
    checks++; if (debug[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL be_full got=%h exp=deadbeef", debug[1]); end
    bus(1'b1, 5'h04, 4'h1, 32'h00000011, r);
    checks++; if (debug[1] !== 32'hDEADBE11) begin errors++; $display("FAIL be_byte0 got=%h exp=deadbe11", debug[1]); end
    checks++; if (debug[0] !== 32'd0) begin errors++; $display("FAIL be_other got=%h exp=0", debug[0]); end
    bus(1'b0, 5'h04, 4'h0, 32'd0, r);
    checks++; if (r !== 32'hDEADBE11) begin errors++; $display("FAIL be_readback got=%h exp=deadbe11", r); end
  endtask

  task automatic test_led();
    logic [31:0] r;
    bus(1'b1, 5'h10, 4'hF, 32'hFFFFFFFF, r);
    checks++; if (led !== 4'hF) begin errors++; $display("FAIL led_write got=%h exp=f", led); end
    bus(1'b0, 5'h10, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h0000000F) begin errors++; $display("FAIL led_read got=%h exp=0000000f", r); end
    bus(1'b1, 5'h10, 4'hE, 32'd0, r);
    checks++; if (led !== 4'hF) begin errors++; $display("FAIL led_be0_off got=%h exp=f", led); end
    bus(1'b0, 5'h13, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h0000000F) begin errors++; $display("FAIL led_lowaddr got=%h exp=0000000f", r); end
    bus(1'b1, 5'h1C, 4'hF, 32'h12345678, r);
    bus(1'b0, 5'h1C, 4'h0, 32'd0, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL reserved_read got=%h exp=0", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    logic [7:0]  s [5];
    s = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    mbx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus(1'b1, 5'h18, 4'h1, {24'hABCDEF, s[i]}, r);
      if (i == 0) begin
        checks++;
        if (mbx_valid !== 1'b1 || mbx_data !== 8'h41) begin
          errors++; $display("FAIL ovf_first_push got=%b/%h exp=1/41", mbx_valid, mbx_data);
        end
      end
    end
    bus(1'b0, 5'h18, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h141) begin errors++; $display("FAIL ovf_status1 got=%h exp=141", r); end
    bus(1'b0, 5'h18, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h041) begin errors++; $display("FAIL ovf_status2 got=%h exp=041", r); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mbx_valid !== 1'b1 || mbx_data !== s[i]) begin
        errors++; $display("FAIL ovf_pop%0d got=%b/%h exp=1/%h", i, mbx_valid, mbx_data, s[i]);
      end
      mbx_ready = 1'b1;
      @(negedge clk);
      mbx_ready = 1'b0;
    end
    checks++; if (mbx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", mbx_valid); end
    bus(1'b0, 5'h18, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h002) begin errors++; $display("FAIL ovf_status_empty got=%h exp=002", r); end
  endtask

  task automatic test_push_pop();
    logic [31:0] r;
    logic [7:0]  s [4];
    logic [7:0]  o [4];
    s = '{8'h57, 8'h58, 8'h59, 8'h56};
    o = '{8'h58, 8'h59, 8'h56, 8'h5A};
    mbx_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus(1'b1, 5'h18, 4'h1, {24'd0, s[i]}, r);
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 5'h18; be = 4'h1; wdata = 32'h0000005A; mbx_ready = 1'b1;
    @(negedge clk);
    req = 1'b0; mbx_ready = 1'b0;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL pp_ack got=%b exp=1", ack); end
    bus(1'b0, 5'h18, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h041) begin errors++; $display("FAIL pp_status got=%h exp=041", r); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mbx_valid !== 1'b1 || mbx_data !== o[i]) begin
        errors++; $display("FAIL pp_pop%0d got=%b/%h exp=1/%h", i, mbx_valid, mbx_data, o[i]);
      end
      mbx_ready = 1'b1;
      @(negedge clk);
      mbx_ready = 1'b0;
    end
    checks++; if (mbx_valid !== 1'b0) begin errors++; $display("FAIL pp_drained got=%b exp=0", mbx_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 5'h08; be = 4'hF; wdata = 32'h00000055; xres = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rmid_ack_in_reset got=%b exp=0", ack); end
    req = 1'b0;
    @(negedge clk);
    xres = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rmid_ack_after got=%b exp=0", ack); end
    checks++; if (debug[2] !== 32'd0) begin errors++; $display("FAIL rmid_debug2 got=%h exp=0", debug[2]); end
    checks++; if (debug[1] !== 32'd0) begin errors++; $display("FAIL rmid_debug1 got=%h exp=0", debug[1]); end
  endtask

  // Random traffic against a model built from registers, a byte queue and a sticky flag.
  task automatic test_random();
    logic [31:0] m_dbg [4];
    logic [3:0]  m_led;
    logic [31:0] m_cyc;
    logic [7:0]  q [$];
    bit          m_ovf;
    bit          e_ack;
    logic [31:0] e_rd;
    logic [2:0]  wi;
    bit          acc;
    bit          pop;
    int          sz;
    int          pick;
    @(negedge clk);
    xres = 1'b0; req = 1'b0; mbx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    xres = 1'b1;
    for (int i = 0; i < 4; i++) m_dbg[i] = '0;
    m_led = '0; m_cyc = '0; q = {}; m_ovf = 0; e_ack = 0; e_rd = '0;
    for (int n = 0; n < 800; n++) begin
      req   = ($urandom_range(0, 2) != 0);
      wr    = $urandom_range(0, 1) == 1;
      pick  = $urandom_range(0, 10);
      wi    = (pick > 7) ? 3'd6 : 3'(pick);
      addr  = {wi, 2'($urandom_range(0, 3))};
      be    = 4'($urandom);
      wdata = $urandom;
      mbx_ready = ($urandom_range(0, 3) == 0);
      acc = req && !e_ack;
      sz  = q.size();
      pop = (sz != 0) && mbx_ready;
      e_rd = '0;
      if (acc && !wr) begin
        if (wi < 3'd4) e_rd = m_dbg[wi[1:0]];
        else if (wi == 3'd4) e_rd = {28'd0, m_led};
        else if (wi == 3'd5) e_rd = m_cyc + 32'd1;
        else if (wi == 3'd6) e_rd = (m_ovf ? 32'h100 : 32'h0) | ((sz % 16) << 4)
                                     | (sz == 0 ? 32'h2 : 32'h0) | (sz == DEPTH ? 32'h1 : 32'h0);
        if (wi == 3'd6) m_ovf = 0;
      end
      if (pop) void'(q.pop_front());
      if (acc && wr) begin
        if (wi < 3'd4) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) m_dbg[wi[1:0]][b*8 +: 8] = wdata[b*8 +: 8];
        end else if (wi == 3'd4 && be[0]) begin
          m_led = wdata[3:0];
        end else if (wi == 3'd6 && be[0]) begin
          if (sz < DEPTH || pop) q.push_back(wdata[7:0]);
          else m_ovf = 1;
        end
      end
      e_ack = acc;
      m_cyc = m_cyc + 32'd1;
      @(negedge clk);
      checks++; if (ack !== e_ack) begin errors++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, ack, e_ack); end
      checks++; if (rdata !== e_rd) begin errors++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, rdata, e_rd); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (debug[i] !== m_dbg[i]) begin
          errors++; $display("FAIL rnd_debug%0d n=%0d got=%h exp=%h", i, n, debug[i], m_dbg[i]);
        end
      end
      checks++; if (led !== m_led) begin errors++; $display("FAIL rnd_led n=%0d got=%h exp=%h", n, led, m_led); end
      checks++;
      if (mbx_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_mbx_valid n=%0d got=%b exp=%b", n, mbx_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (mbx_data !== q[0]) begin errors++; $display("FAIL rnd_mbx_data n=%0d got=%h exp=%h", n, mbx_data, q[0]); end
      end
    end
    req = 1'b0; mbx_ready = 1'b0;
  endtask

  initial begin
    xres = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0; mbx_ready = 1'b0;
    test_reset();
    test_byte_en();
    test_led();
    test_overflow();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
